// File: rtl/i2lbs_integral_window_stream.sv
// Streaming integral-image box filter: builds the integral image of a raster pixel
// stream in a (WIN_H+1)-row ring and emits one WIN_W x WIN_H box sum per stride grid point.
module i2lbs_integral_window_stream #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int II_WIDTH     = 24,
    parameter int FRAME_WIDTH  = 10,
    parameter int FRAME_HEIGHT = 10,
    parameter int WIN_W        = 3,
    parameter int WIN_H        = 3,
    parameter int STRIDE       = 1,
    parameter int COORD_WIDTH  = 12
) (
    input  logic                   clk_os,
    input  logic                   reset_os,
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    input  logic                   i_valid,
    input  logic                   i_sof,
    output logic                   o_ready,
    output logic [II_WIDTH-1:0]    o_window_sum,
    output logic [COORD_WIDTH-1:0] o_win_x,
    output logic [COORD_WIDTH-1:0] o_win_y,
    output logic                   o_valid,
    input  logic                   i_out_ready,
    output logic                   o_frame_done
);

    localparam int XW        = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int YW        = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int RING_ROWS = WIN_H + 1;
    localparam int RW        = $clog2(RING_ROWS);
    localparam bit HAS_B     = (FRAME_HEIGHT > WIN_H);
    localparam bit HAS_C     = (FRAME_WIDTH > WIN_W);

    localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
    localparam logic [XW-1:0] X_WMIN  = XW'(WIN_W - 1);
    localparam logic [YW-1:0] Y_WMIN  = YW'(WIN_H - 1);
    localparam logic [XW-1:0] X_WW    = XW'(WIN_W);
    localparam logic [YW-1:0] Y_WH    = YW'(WIN_H);
    localparam logic [RW-1:0] R_LAST  = RW'(WIN_H);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [RW-1:0]      ring_row;
    logic [II_WIDTH-1:0] row_acc;
    logic [II_WIDTH-1:0] ring [RING_ROWS][FRAME_WIDTH];

    logic                accept, start, process, win_hit, last_col, last_row;
    logic [XW-1:0]       ex, wx;
    logic [YW-1:0]       ey, wy;
    logic [RW-1:0]       er, prev_row, top_row;
    logic [II_WIDTH-1:0] acc_new, above, d_val, b_val, c_val, a_val;
    logic                has_b, has_c;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the input side is ready whenever the output slot is empty or draining this cycle.
    assign o_ready = !o_valid || i_out_ready;

    always_comb begin
        accept   = i_valid && o_ready;
        start    = i_sof || (state == IDLE);
        process  = accept && ((state == ACTIVE) || i_sof);
        ex       = start ? '0 : x;
        ey       = start ? '0 : y;
        er       = start ? '0 : ring_row;
        prev_row = (er == '0) ? R_LAST : er - 1'b1;
        top_row  = (er == R_LAST) ? '0 : er + 1'b1;
        last_col = (ex == X_LAST);
        last_row = (ey == Y_LAST);
        acc_new  = (start ? '0 : row_acc) + II_WIDTH'(i_pixel);
        above    = (ey != '0) ? ring[prev_row][ex] : '0;
        d_val    = acc_new + above;
        // Corners above or left of the frame read as zero; the ring may hold stale data there.
        has_b    = HAS_B && (ey >= Y_WH);
        has_c    = HAS_C && (ex >= X_WW);
        b_val    = has_b ? ring[top_row][ex] : '0;
        c_val    = has_c ? ring[er][ex - X_WW] : '0;
        a_val    = (has_b && has_c) ? ring[top_row][ex - X_WW] : '0;
        wx       = ex - X_WMIN;
        wy       = ey - Y_WMIN;
        win_hit  = (ex >= X_WMIN) && (ey >= Y_WMIN)
                && ((32'(wx) % 32'(STRIDE)) == 32'd0)
                && ((32'(wy) % 32'(STRIDE)) == 32'd0);
    end

    always_ff @(posedge clk_os) begin
        if (process) ring[er][ex] <= d_val;
    end

    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            ring_row     <= '0;
            row_acc      <= '0;
            o_valid      <= 1'b0;
            o_window_sum <= '0;
            o_win_x      <= '0;
            o_win_y      <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (process) begin
                if (last_col && last_row) begin
                    state        <= IDLE;
                    x            <= '0;
                    y            <= '0;
                    ring_row     <= '0;
                    row_acc      <= '0;
                    o_frame_done <= 1'b1;
                end else if (last_col) begin
                    state    <= ACTIVE;
                    x        <= '0;
                    y        <= ey + 1'b1;
                    ring_row <= top_row;
                    row_acc  <= '0;
                end else begin
                    state    <= ACTIVE;
                    x        <= ex + 1'b1;
                    y        <= ey;
                    ring_row <= er;
                    row_acc  <= acc_new;
                end
            end
            // A new window overrides a concurrent drain, so the slot stays full.
            if (process && win_hit) begin
                o_valid      <= 1'b1;
                o_window_sum <= d_val - b_val - c_val + a_val;
                o_win_x      <= COORD_WIDTH'(wx);
                o_win_y      <= COORD_WIDTH'(wy);
            end else if (o_valid && i_out_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2lbs_integral_window_stream.sv
// Bench for the streaming integral window block: three instances (default, 4x4/2x2/stride 2,
// 12-bit integral) checked against a direct window-summing model.
module tb_i2lbs_integral_window_stream;

    localparam int NK = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        vld [NK];
    logic        sof [NK];
    logic        ordy [NK];
    logic [7:0]  pix [NK];
    logic        o_rdy [NK];
    logic        ov [NK];
    logic        fdone [NK];
    logic [11:0] ox [NK];
    logic [11:0] oy [NK];
    logic [23:0] osum [NK];
    logic [23:0] sum0, sum1;
    logic [11:0] sum2;

    int          checks = 0;
    int          errors = 0;
    int          img [NK][10][10];
    bit          m_idle [NK];
    int          mx [NK], my [NK];
    bit          fd_exp [NK];
    bit          prev_stall [NK];
    logic [48:0] held [NK];
    int          win_cnt [NK], fd_cnt [NK], sum_acc [NK];
    bit          rnd_rdy [NK];
    logic [49:0] exp_q [$];

    assign osum[0] = sum0;
    assign osum[1] = sum1;
    assign osum[2] = {12'd0, sum2};

    i2lbs_integral_window_stream dut0 (
        .clk_os(clk), .reset_os(rst_n), .i_pixel(pix[0]), .i_valid(vld[0]), .i_sof(sof[0]),
        .o_ready(o_rdy[0]), .o_window_sum(sum0), .o_win_x(ox[0]), .o_win_y(oy[0]),
        .o_valid(ov[0]), .i_out_ready(ordy[0]), .o_frame_done(fdone[0]));

    i2lbs_integral_window_stream #(.FRAME_WIDTH(4), .FRAME_HEIGHT(4), .WIN_W(2), .WIN_H(2),
        .STRIDE(2)) dut1 (
        .clk_os(clk), .reset_os(rst_n), .i_pixel(pix[1]), .i_valid(vld[1]), .i_sof(sof[1]),
        .o_ready(o_rdy[1]), .o_window_sum(sum1), .o_win_x(ox[1]), .o_win_y(oy[1]),
        .o_valid(ov[1]), .i_out_ready(ordy[1]), .o_frame_done(fdone[1]));

    i2lbs_integral_window_stream #(.II_WIDTH(12)) dut2 (
        .clk_os(clk), .reset_os(rst_n), .i_pixel(pix[2]), .i_valid(vld[2]), .i_sof(sof[2]),
        .o_ready(o_rdy[2]), .o_window_sum(sum2), .o_win_x(ox[2]), .o_win_y(oy[2]),
        .o_valid(ov[2]), .i_out_ready(ordy[2]), .o_frame_done(fdone[2]));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int p_fw(int k); return (k == 1) ? 4 : 10; endfunction
    function automatic int p_win(int k); return (k == 1) ? 2 : 3; endfunction
    function automatic int p_st(int k); return (k == 1) ? 2 : 1; endfunction
    function automatic int unsigned p_mask(int k); return (k == 2) ? 32'hfff : 32'hffffff; endfunction

    task automatic model_accept(input int k, input int p, input bit is_sof);
        int wx, wy, fw;
        int unsigned acc;
        fw = p_fw(k);
        if (m_idle[k] && !is_sof) return;
        if (is_sof) begin mx[k] = 0; my[k] = 0; end
        m_idle[k] = 1'b0;
        img[k][my[k]][mx[k]] = p;
        wx = mx[k] - p_win(k) + 1;
        wy = my[k] - p_win(k) + 1;
        if (wx >= 0 && wy >= 0 && (wx % p_st(k)) == 0 && (wy % p_st(k)) == 0) begin
            acc = 0;
            for (int yy = wy; yy <= my[k]; yy++)
                for (int xx = wx; xx <= mx[k]; xx++)
                    acc += img[k][yy][xx];
            exp_q.push_back({2'(k), 12'(wx), 12'(wy), 24'(acc & p_mask(k))});
        end
        if (mx[k] == fw - 1 && my[k] == fw - 1) begin
            fd_exp[k] = 1'b1;
            m_idle[k] = 1'b1;
            mx[k] = 0;
            my[k] = 0;
        end else if (mx[k] == fw - 1) begin
            mx[k] = 0;
            my[k]++;
        end else begin
            mx[k]++;
        end
    endtask

    task automatic reset_models();
        for (int k = 0; k < NK; k++) begin
            m_idle[k] = 1'b1; mx[k] = 0; my[k] = 0; fd_exp[k] = 1'b0; prev_stall[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) begin prev_stall[k] = 1'b0; fd_exp[k] = 1'b0; end
        end else begin
            for (int k = 0; k < NK; k++) begin
                checks++;
                if (fdone[k] !== fd_exp[k]) begin
                    errors++;
                    $display("FAIL frame_done k=%0d got %b exp %b", k, fdone[k], fd_exp[k]);
                end
                if (fdone[k] === 1'b1) fd_cnt[k]++;
                fd_exp[k] = 1'b0;
                checks++;
                if (o_rdy[k] !== (!ov[k] || ordy[k])) begin
                    errors++;
                    $display("FAIL o_ready k=%0d got %b exp %b", k, o_rdy[k], !ov[k] || ordy[k]);
                end
                if (prev_stall[k]) begin
                    checks++;
                    if ({ov[k], ox[k], oy[k], osum[k]} !== held[k]) begin
                        errors++;
                        $display("FAIL stall_hold k=%0d got %h exp %h", k,
                                 {ov[k], ox[k], oy[k], osum[k]}, held[k]);
                    end
                end
                prev_stall[k] = ov[k] && !ordy[k];
                held[k] = {ov[k], ox[k], oy[k], osum[k]};
                if (ov[k] && ordy[k]) begin
                    logic [49:0] e;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL window k=%0d got x=%0d y=%0d sum=%0d exp none", k,
                                 ox[k], oy[k], osum[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if ({2'(k), ox[k], oy[k], osum[k]} !== e) begin
                            errors++;
                            $display("FAIL window k=%0d got x=%0d y=%0d sum=%0d exp k=%0d x=%0d y=%0d sum=%0d",
                                     k, ox[k], oy[k], osum[k], e[49:48], e[47:36], e[35:24], e[23:0]);
                        end
                    end
                    win_cnt[k]++;
                    sum_acc[k] += int'(osum[k]);
                end
                if (vld[k] && o_rdy[k]) model_accept(k, int'(pix[k]), sof[k]);
            end
        end
    end

    // Random consumer readiness, enabled per instance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NK; k++)
                if (rnd_rdy[k]) ordy[k] = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pixel(input int k, input int p, input bit is_sof);
        bit got = 1'b0;
        vld[k] = 1'b1; pix[k] = 8'(p); sof[k] = is_sof;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (o_rdy[k]) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        vld[k] = 1'b0; sof[k] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout k=%0d got not-accepted exp accepted", k);
        end
    endtask

    // mode 0: all 1, 1: all 255, 2: x+4y, 3: random
    task automatic send_frame(input int k, input int mode);
        int fw = p_fw(k);
        for (int i = 0; i < fw * fw; i++) begin
            int p;
            case (mode)
                0: p = 1;
                1: p = 255;
                2: p = (i % fw) + 4 * (i / fw);
                default: p = int'($urandom_range(0, 255));
            endcase
            send_pixel(k, p, i == 0);
        end
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ov[k]) break;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || ov[k]) begin
            errors++;
            $display("FAIL drain k=%0d got pending=%0d valid=%b exp 0 0", k, exp_q.size(), ov[k]);
        end
    endtask

    task automatic check_counts(input string name, input int k, input int w0, input int f0,
                                input int wexp, input int fexp);
        checks++;
        if (win_cnt[k] - w0 != wexp) begin
            errors++;
            $display("FAIL %s_windows got %0d exp %0d", name, win_cnt[k] - w0, wexp);
        end
        checks++;
        if (fd_cnt[k] - f0 != fexp) begin
            errors++;
            $display("FAIL %s_frame_done got %0d exp %0d", name, fd_cnt[k] - f0, fexp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            checks++;
            if ({ov[k], fdone[k], o_rdy[k]} !== 3'b001 || ox[k] !== 12'd0 || oy[k] !== 12'd0
                || osum[k] !== 24'd0) begin
                errors++;
                $display("FAIL reset_values k=%0d got v=%b fd=%b rdy=%b x=%0d y=%0d sum=%0d exp 0 0 1 0 0 0",
                         k, ov[k], fdone[k], o_rdy[k], ox[k], oy[k], osum[k]);
            end
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (ov[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset k=%0d got %b exp 0", k, ov[k]);
            end
        end
    endtask

    task automatic test_all_ones();
        int w0 = win_cnt[0], f0 = fd_cnt[0];
        send_frame(0, 0);
        drain(0);
        check_counts("all_ones", 0, w0, f0, 64, 1);
        checks++;
        if (sum_acc[0] != 64 * 9) begin
            errors++;
            $display("FAIL all_ones_sum got %0d exp %0d", sum_acc[0], 64 * 9);
        end
    endtask

    task automatic test_stride();
        int w0 = win_cnt[1], f0 = fd_cnt[1], s0 = sum_acc[1];
        send_frame(1, 2);
        drain(1);
        check_counts("stride", 1, w0, f0, 4, 1);
        checks++;
        if (sum_acc[1] - s0 != 120) begin
            errors++;
            $display("FAIL stride_sum got %0d exp 120", sum_acc[1] - s0);
        end
    endtask

    task automatic test_backpressure();
        int w0 = win_cnt[1], f0 = fd_cnt[1], s0 = sum_acc[1];
        rnd_rdy[1] = 1'b1;
        send_frame(1, 2);
        drain(1);
        rnd_rdy[1] = 1'b0;
        @(posedge clk); #1 ordy[1] = 1'b1;
        check_counts("backpressure", 1, w0, f0, 4, 1);
        checks++;
        if (sum_acc[1] - s0 != 120) begin
            errors++;
            $display("FAIL backpressure_sum got %0d exp 120", sum_acc[1] - s0);
        end
    endtask

    task automatic test_idle_discard();
        int w0 = win_cnt[0], f0 = fd_cnt[0];
        rnd_rdy[0] = 1'b1;
        for (int i = 0; i < 5; i++) send_pixel(0, int'($urandom_range(0, 255)), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov[0] !== 1'b0 || win_cnt[0] != w0) begin
            errors++;
            $display("FAIL idle_discard got valid=%b windows=%0d exp 0 0", ov[0], win_cnt[0] - w0);
        end
        send_frame(0, 3);
        drain(0);
        rnd_rdy[0] = 1'b0;
        @(posedge clk); #1 ordy[0] = 1'b1;
        check_counts("idle_frame", 0, w0, f0, 64, 1);
    endtask

    task automatic test_sof_restart();
        int w0 = win_cnt[0], f0 = fd_cnt[0];
        for (int i = 0; i < 45; i++) send_pixel(0, int'($urandom_range(0, 255)), i == 0);
        send_pixel(0, int'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 99; i++) send_pixel(0, int'($urandom_range(0, 255)), 1'b0);
        drain(0);
        check_counts("sof_restart", 0, w0, f0, 19 + 64, 1);
    endtask

    task automatic test_wrap();
        int w0 = win_cnt[2], f0 = fd_cnt[2], s0 = sum_acc[2];
        send_frame(2, 1);
        drain(2);
        check_counts("wrap", 2, w0, f0, 64, 1);
        checks++;
        if (sum_acc[2] - s0 != 64 * 2295) begin
            errors++;
            $display("FAIL wrap_sum got %0d exp %0d", sum_acc[2] - s0, 64 * 2295);
        end
    endtask

    task automatic test_reset_mid();
        int w0, f0;
        for (int i = 0; i < 32; i++) send_pixel(2, int'($urandom_range(0, 255)), i == 0);
        repeat (2) @(posedge clk);
        #1 ordy[2] = 1'b0;
        send_pixel(2, int'($urandom_range(0, 255)), 1'b0);
        checks++;
        if (ov[2] !== 1'b1) begin
            errors++;
            $display("FAIL pending_before_reset got %b exp 1", ov[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov[2] !== 1'b0 || fdone[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got valid=%b fd=%b exp 0 0", ov[2], fdone[2]);
        end
        reset_models();
        ordy[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        w0 = win_cnt[2]; f0 = fd_cnt[2];
        send_frame(2, 3);
        drain(2);
        check_counts("after_reset", 2, w0, f0, 64, 1);
    endtask

    initial begin
        for (int k = 0; k < NK; k++) begin
            vld[k] = 1'b0; sof[k] = 1'b0; pix[k] = 8'd0; ordy[k] = 1'b1; rnd_rdy[k] = 1'b0;
            win_cnt[k] = 0; fd_cnt[k] = 0; sum_acc[k] = 0;
        end
        reset_models();
        test_reset();
        test_all_ones();
        test_stride();
        test_backpressure();
        test_idle_discard();
        test_sof_restart();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
